iter_div_unit: RTL and testbench
================================

ITER_DIV_UNIT -- requirements
Module: iter_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1: reset reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1, request for a new operation, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port rs1, input, XLEN, dividend.
REQ-007 SHALL have port rs2, input, XLEN, divisor.
REQ-008 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, XLEN, quotient or remainder, held until the next accepted start.
REQ-011 SHALL have port stall, output, 1, hold request to the downstream EX/MEM pipeline register load.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 In IDLE with start=1, SHALL latch op, rs1 and rs2; for DIV/REM SHALL also latch their absolute values and signs.
REQ-014 IDLE+start SHALL go to DONE next cycle when rs2==0 or the signed overflow case applies; otherwise SHALL go to CALC.
REQ-015 CALC SHALL run unsigned restoring shift-subtract, one quotient bit per cycle, for exactly XLEN cycles counted by a $clog2(XLEN)+1-bit counter, then go to DONE.
REQ-016 On entering DONE, SHALL register the sign-corrected result; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-017 Latency: start accepted at edge T; done=1 in cycle T+XLEN+1 for the normal path and in cycle T+1 for special cases.
REQ-018 Sign rules: DIV quotient negated when operand signs differ; REM remainder takes the dividend's sign.
REQ-019 Divide by zero: quotient SHALL be all ones (DIV and DIVU); remainder SHALL be rs1.
REQ-020 Signed overflow (rs1=100...0, rs2=all ones, op DIV/REM): quotient SHALL be rs1; remainder SHALL be 0.
REQ-021 stall = (state==IDLE && start) || state==CALC; stall SHALL be 0 in DONE so the downstream register captures result.
REQ-022 start while busy=1 SHALL be ignored; the operation in progress SHALL NOT be disturbed.
REQ-023 start in the DONE cycle SHALL be ignored; a new operation is accepted only from IDLE.
REQ-024 done SHALL never be high for two consecutive cycles.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE and set done=0, busy=0, result=0, counter=0 and all internal operand registers to 0.
REQ-026 Reset mid-CALC SHALL abort the operation with no done pulse; stall SHALL be 0 in the cycle after reset.
REQ-027 reset SHALL take priority over start at the same edge.

Structure
REQ-028 Shared package riscv_pkg SHALL hold the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU) and the FSM state localparams.
REQ-029 A single sub-module div_core SHALL hold the unsigned shift-subtract datapath: remainder/quotient registers and counter, with load/step/finish controls.
REQ-030 Sign correction and special-case muxing SHALL stay in iter_div_unit.

Verification
REQ-031 DIVU rs1=100, rs2=7 -> done in cycle T+33, result=14; REMU with the same operands -> result=2.
REQ-032 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-033 DIV rs1=5, rs2=0 -> result 0xFFFFFFFF, done in cycle T+1; REMU with the same operands -> result 5.
REQ-034 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> result 0x80000000 at T+1; REM with the same operands -> 0.
REQ-035 Start DIVU, assert reset in CALC cycle 10 -> next cycle busy=0, stall=0, done=0, result=0, and no done pulse afterwards.
REQ-036 Pulse start with new operands during CALC and again in the DONE cycle -> the first result is unchanged, and exactly one done pulse occurs.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the iterative divide unit: RISC-V M-extension divide
// op selects and the divider FSM state values.
package riscv_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } div_state_t;

endpackage

// File: rtl/div_core.sv
// Unsigned restoring shift-subtract divider datapath: one quotient bit per step.
// Exposes the post-step quotient/remainder so the caller can register the final bit.
module div_core
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic            finish,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quo_next,
   output logic [XLEN-1:0] rem_next,
   output logic            last
);

   localparam int CW = $clog2(XLEN) + 1;

   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvs;
   logic [CW-1:0]   cnt;
   logic [XLEN:0]   partial;
   logic [XLEN:0]   diff;

   // Partial remainder always fits XLEN bits, so the shifted value needs one extra bit.
   assign partial = {rem, quo[XLEN-1]};
   assign diff    = partial - {1'b0, dvs};

   always_comb begin
      rem_next = partial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
      if (!diff[XLEN]) begin
         rem_next = diff[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b1};
      end
   end

   assign last = (cnt == CW'(XLEN - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (load) begin
         rem <= '0;
         quo <= dividend;
         dvs <= divisor;
         cnt <= '0;
      end else begin
         if (step) begin
            rem <= rem_next;
            quo <= quo_next;
         end
         if (finish)
            cnt <= '0;
         else if (step)
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit: operand sign handling, special
// cases (divide by zero, signed overflow) and pipeline stall control.
module iter_div_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            stall
);

   function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
      return v[XLEN-1] ? -v : v;
   endfunction

   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag,
                                                  input logic            neg);
      return neg ? -mag : mag;
   endfunction

   div_state_t      state;
   div_state_t      state_next;
   logic [1:0]      op_q;
   logic            sign1_q;
   logic            sign2_q;
   logic            signed_op;
   logic            div_zero;
   logic            overflow;
   logic            special;
   logic [XLEN-1:0] special_res;
   logic [XLEN-1:0] abs1;
   logic [XLEN-1:0] abs2;
   logic            core_load;
   logic            core_step;
   logic            core_finish;
   logic            core_last;
   logic [XLEN-1:0] core_quo_next;
   logic [XLEN-1:0] core_rem_next;
   logic            q_neg;
   logic            r_neg;

   assign signed_op = (op == OP_DIV) || (op == OP_REM);
   assign div_zero  = (rs2 == '0);
   assign overflow  = signed_op && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
   assign special   = div_zero || overflow;
   assign abs1      = signed_op ? abs_val(rs1) : rs1;
   assign abs2      = signed_op ? abs_val(rs2) : rs2;

   // op[1] selects remainder; divide-by-zero wins over overflow (they are disjoint anyway).
   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = op[1] ? rs1 : '1;
      else
         special_res = op[1] ? '0 : rs1;
   end

   assign q_neg = (op_q == OP_DIV) && (sign1_q ^ sign2_q);
   assign r_neg = (op_q == OP_REM) && sign1_q;

   always_comb begin
      state_next  = state;
      core_load   = 1'b0;
      core_step   = 1'b0;
      core_finish = 1'b0;
      stall       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               core_load  = 1'b1;
               stall      = 1'b1;
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            core_step = 1'b1;
            stall     = 1'b1;
            if (core_last) begin
               core_finish = 1'b1;
               state_next  = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= '0;
         sign1_q <= 1'b0;
         sign2_q <= 1'b0;
         result  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            op_q    <= op;
            sign1_q <= signed_op && rs1[XLEN-1];
            sign2_q <= signed_op && rs2[XLEN-1];
            if (special)
               result <= special_res;
         end
         if (state == CALC && core_last)
            result <= op_q[1] ? apply_sign(core_rem_next, r_neg)
                              : apply_sign(core_quo_next, q_neg);
      end
   end

   div_core #(
      .XLEN(XLEN)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (core_load),
      .step     (core_step),
      .finish   (core_finish),
      .dividend (abs1),
      .divisor  (abs2),
      .quo_next (core_quo_next),
      .rem_next (core_rem_next),
      .last     (core_last)
   );

endmodule

// File: tb/tb_iter_div_unit.sv
// Randomized and directed bench for iter_div_unit against an arithmetic
// reference of the RISC-V divide/remainder rules.
module tb_iter_div_unit;
   import riscv_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        stall;

   int n_checks;
   int n_pass;
   int done_pulses;

   iter_div_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .done   (done),
      .result (result),
      .stall  (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) done_pulses <= done_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         OP_DIV:  return ovf ? a : 32'($signed(a) / $signed(b));
         OP_DIVU: return a / b;
         OP_REM:  return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] exp;
      int          exp_lat;
      int          lat;
      exp     = ref_div(o, a, b);
      exp_lat = ref_lat(o, a, b);
      @(negedge clk);
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      #1 chk({tag, "_stall_req"}, 32'(stall), 32'd1);
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, result, exp);
      chk({tag, "_stall_done"}, 32'(stall), 32'd0);
      @(posedge clk);
      #1 chk({tag, "_done_drop"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          p0;
      int          lat;

      n_checks = 0; n_pass = 0; done_pulses = 0;
      reset = 1'b1; start = 1'b0; op = OP_DIV; rs1 = '0; rs2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_result", result, 32'd0);
      reset = 1'b0;

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
      run_op("div_5_0", OP_DIV, 32'd5, 32'd0);
      run_op("remu_5_0", OP_REMU, 32'd5, 32'd0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE);

      // Reset in the middle of CALC aborts without a done pulse.
      @(negedge clk);
      op = OP_DIVU; rs1 = 32'd12345; rs2 = 32'd11; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", result, 32'd0);
      reset = 1'b0;
      p0 = done_pulses;
      repeat (40) @(posedge clk);
      #1 chk("abort_no_done", 32'(done_pulses - p0), 32'd0);

      // Starts while busy and in the DONE cycle are ignored.
      @(negedge clk);
      op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      p0 = done_pulses;
      repeat (4) @(posedge clk);
      #1 op = OP_REMU; rs1 = 32'd77; rs2 = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 6;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("ign_lat", 32'(lat), 32'd33);
      chk("ign_res", result, 32'd142);
      op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("ign_done_start_busy", 32'(busy), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("ign_one_pulse", 32'(done_pulses - p0), 32'd1);
      chk("ign_res_held", result, 32'd142);

      for (int i = 0; i < 150; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
            3: rb = 32'($signed(-$urandom_range(1, 100)));
            4: ra = 32'($signed(-$urandom_range(0, 100000)));
            default: ;
         endcase
         run_op("rand", ro, ra, rb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
